fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle RISC-V core; it sits directly upstream of the main control decoder. It owns the program counter, issues word requests to instruction memory over a request/grant/response interface, and buffers returned words in a small FIFO. It presents each word to the decode/control stage with a valid/ready handshake. A redirect input from the branch/jump resolution logic flushes the buffered words and restarts fetch at a new PC.

---
 rtl/core_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage.
package core_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {word, pc} entries with flush; head reads 0 when empty.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Gating the head keeps instr/instr_pc at zero out of reset without clearing storage.
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem request, buffers words for decode.
// States: IDLE no credit / nothing outstanding | REQ request held | WAIT granted, awaiting response
module fetch_unit import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            discard_q, discard_d;
  logic [CNT_W-1:0] count, count_next;
  logic [2*XLEN-1:0] head;
  logic            push, pop, credit;

  assign push        = (state_q == WAIT) && imem_rvalid && !discard_q && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr_valid = (count != '0);
  assign {instr, instr_pc} = head;
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_pc_q;

  // Credit is judged on the occupancy that will hold after this cycle's push/pop/flush.
  always_comb begin
    count_next = count;
    if (redirect)          count_next = '0;
    else if (push && !pop) count_next = count + CNT_W'(1);
    else if (!push && pop) count_next = count - CNT_W'(1);
  end
  assign credit = (count_next < CNT_W'(DEPTH));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    discard_d     = discard_q;
    case (state_q)
      IDLE: if (credit) state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + PC_INC;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = credit ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides the PC; a response still in flight must be drained and dropped.
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      if ((state_q == REQ && imem_gnt) || (state_q == WAIT && !imem_rvalid))
        discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2 * XLEN)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({imem_rdata, inflight_pc_q}),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (count),
    .head_o      (head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready));

  // Second instance starting just below the top of the address space, zero-wait memory.
  logic        w_req, w_valid, w_rvalid = 1'b0;
  logic        w_gnt = 1'b1, w_redir = 1'b0, w_ready = 1'b1;
  logic [31:0] w_addr, w_instr, w_instr_pc, w_rdata = '0, w_rpc = '0;
  logic [31:0] wlog[$];
  logic [63:0] wvlog[$];

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .redirect(w_redir), .redirect_pc(w_rpc),
    .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(w_ready));

  always @(posedge clk) begin
    if (!rst_n) begin
      w_rvalid <= 1'b0;
      wlog.delete();
      wvlog.delete();
    end else begin
      w_rvalid <= w_req;
      if (w_req) begin
        w_rdata <= ~w_addr;
        wlog.push_back(w_addr);
      end
      if (w_valid) wvlog.push_back({w_instr, w_instr_pc});
    end
  end

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0033 : (a ^ 32'h5A5A_0013);
  endfunction

  // Behavioural model: request flag, in-flight tracking and a queue of buffered words.
  bit          m_req, m_inflight, m_discard;
  logic [31:0] m_pc, m_in_addr;
  logic [63:0] m_buf[$];

  task automatic model_step();
    bit pop;
    if (!rst_n) begin
      m_req = 0; m_inflight = 0; m_discard = 0; m_pc = RPC; m_in_addr = RPC;
      m_buf.delete();
    end else begin
      pop = (m_buf.size() > 0) && instr_ready;
      if (redirect) begin
        m_buf.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (m_inflight) begin
          if (imem_rvalid) begin m_inflight = 0; m_discard = 0; m_req = 1; end
          else m_discard = 1;
        end else if (m_req && imem_gnt) begin
          m_inflight = 1; m_discard = 1; m_req = 0;
        end else m_req = 1;
      end else begin
        if (pop) void'(m_buf.pop_front());
        if (m_inflight && imem_rvalid) begin
          if (!m_discard) m_buf.push_back({imem_rdata, m_in_addr});
          m_discard = 0; m_inflight = 0;
        end
        if (m_req && imem_gnt) begin
          m_in_addr = m_pc; m_pc = m_pc + 32'd4; m_inflight = 1; m_req = 0;
        end else if (!m_req && !m_inflight) m_req = (m_buf.size() < DEPTH);
      end
    end
  endtask

  // Instruction memory and stimulus knobs.
  bit          pend = 0, cur_req = 0, f_redir = 0;
  logic [31:0] paddr = '0, cur_addr = '0, f_rpc = '0, stall_addr = 32'hFFFF_FFFF;
  int unsigned pdelay = 0, kmin = 0, kmax = 0, k_gnt = 100, k_ready = 100, k_redir = 0;
  int          stall_left = 0, cnt_stall = 0;
  logic [31:0] glog[$];

  task automatic mem_step();
    if (!rst_n) begin
      pend = 0;
      glog.delete();
    end else begin
      if (imem_rvalid) pend = 0;
      if (cur_req && imem_gnt) begin
        pend = 1; paddr = cur_addr; pdelay = $urandom_range(kmax, kmin);
        glog.push_back(cur_addr);
      end else if (pend && pdelay > 0) pdelay--;
    end
  endtask

  task automatic drive();
    cur_req = imem_req;
    cur_addr = imem_addr;
    if (cur_req && cur_addr == stall_addr) cnt_stall++;
    if (cur_req && cur_addr == stall_addr && stall_left > 0) begin
      imem_gnt = 1'b0; stall_left--;
    end else imem_gnt = ($urandom_range(99, 0) < k_gnt);
    imem_rvalid = pend && (pdelay == 0);
    imem_rdata  = imem_rvalid ? mem_word(paddr) : $urandom();
    instr_ready = ($urandom_range(99, 0) < k_ready);
    if (f_redir) begin
      redirect = 1'b1; redirect_pc = f_rpc; f_redir = 0;
    end else begin
      redirect = ($urandom_range(99, 0) < k_redir);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15, 0))
                                                : 32'($urandom_range(255, 0));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    mem_step();
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", {63'd0, imem_req}, {63'd0, m_req});
      check("imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
      check("instr_valid", {63'd0, instr_valid}, {63'd0, m_buf.size() > 0});
      if (m_buf.size() > 0) begin
        check("instr", {32'd0, instr}, {32'd0, m_buf[0][63:32]});
        check("instr_pc", {32'd0, instr_pc}, {32'd0, m_buf[0][31:0]});
      end
    end
  end

  initial begin
    bit ok;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; redirect = 0; redirect_pc = '0; instr_ready = 0;
    cycle();
    chk_en = 1'b1;
    cycle();
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_addr", {32'd0, imem_addr}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_pc", {32'd0, instr_pc}, 64'd0);

    // Zero-wait memory, consumer always ready.
    rst_n = 1'b1;
    cycle();
    check("first_req", {63'd0, imem_req}, 64'd1);
    check("first_addr", {32'd0, imem_addr}, 64'd0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin ok = 1; break; end
      cycle();
    end
    check("t1_wait", {63'd0, ok}, 64'd1);
    check("t1_instr", {32'd0, instr}, 64'h33);
    check("t1_pc", {32'd0, instr_pc}, 64'd0);
    repeat (4) cycle();
    check("t1_next_addr", {32'd0, (glog.size() > 1) ? glog[1] : 32'hDEAD_BEEF}, 64'h4);
    check("wrap_first", {32'd0, (wlog.size() > 0) ? wlog[0] : 32'h1}, 64'hFFFF_FFFC);
    check("wrap_second", {32'd0, (wlog.size() > 1) ? wlog[1] : 32'h1}, 64'h0);
    check("wrap_word", (wvlog.size() > 0) ? wvlog[0] : 64'h1, {32'h3, 32'hFFFF_FFFC});

    // Consumer stalled: buffer fills after exactly DEPTH requests.
    k_ready = 0; kmax = 1;
    do_reset();
    repeat (20) cycle();
    check("t2_nreq", 64'(glog.size()), 64'd2);
    check("t2_addr0", {32'd0, (glog.size() > 0) ? glog[0] : 32'h1}, 64'h0);
    check("t2_addr1", {32'd0, (glog.size() > 1) ? glog[1] : 32'h1}, 64'h4);
    check("t2_req_low", {63'd0, imem_req}, 64'd0);
    check("t2_hold_pc", {32'd0, instr_pc}, 64'd0);
    check("t2_hold_instr", {32'd0, instr}, 64'h33);
    k_ready = 100;
    repeat (6) cycle();

    // Grant withheld for 3 cycles on address 8.
    kmax = 0;
    do_reset();
    stall_addr = 32'h8; stall_left = 3; cnt_stall = 0;
    repeat (20) cycle();
    check("t3_held_cycles", 64'(cnt_stall), 64'd4);
    stall_addr = 32'hFFFF_FFFF;

    // Redirect while a response is in flight.
    kmin = 2; kmax = 2;
    do_reset();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_inflight) begin ok = 1; break; end
    end
    check("t4_inflight", {63'd0, ok}, 64'd1);
    f_redir = 1; f_rpc = 32'h0000_0102;
    glog.delete();
    cycle();
    cycle();
    check("t4_flushed", {63'd0, instr_valid}, 64'd0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin ok = 1; break; end
      cycle();
    end
    check("t4_wait", {63'd0, ok}, 64'd1);
    check("t4_req_addr", {32'd0, (glog.size() > 0) ? glog[0] : 32'h1}, 64'h100);
    check("t4_pc", {32'd0, instr_pc}, 64'h100);
    check("t4_instr", {32'd0, instr}, 64'h5A5A_0113);

    // Redirect together with a pop on a full buffer.
    kmin = 0; kmax = 0; k_ready = 0;
    do_reset();
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (m_buf.size() == DEPTH) begin ok = 1; break; end
    end
    check("t5_full", {63'd0, ok}, 64'd1);
    k_ready = 100; f_redir = 1; f_rpc = 32'h0000_0040;
    cycle();
    cycle();
    check("t5_empty", {63'd0, instr_valid}, 64'd0);
    check("t5_req", {63'd0, imem_req}, 64'd1);
    check("t5_addr", {32'd0, imem_addr}, 64'h40);

    // Randomized traffic.
    for (int blk = 0; blk < 6; blk++) begin
      k_gnt = $urandom_range(100, 20);
      kmin = $urandom_range(1, 0);
      kmax = kmin + $urandom_range(3, 0);
      k_ready = $urandom_range(100, 0);
      k_redir = $urandom_range(8, 0);
      if (blk % 2 == 1) do_reset();
      repeat (500) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
